// File: rtl/video_sync_gen.sv
// 15 kHz raster timing source: H/V counters, video RAM fetch, and a sync/blank
// alignment pipeline matched to the RAM read latency. Optional: VIDEO_SYNC_GEN_TESTPAT_EN.
`timescale 1ns/1ps
module video_sync_gen #(
    parameter int unsigned H_TOTAL      = 384,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned H_SYNC_START = 288,
    parameter int unsigned H_SYNC_LEN   = 32,
    parameter int unsigned V_TOTAL      = 262,
    parameter int unsigned V_ACTIVE     = 232,
    parameter int unsigned V_SYNC_START = 240,
    parameter int unsigned V_SYNC_LEN   = 3,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic        clk6m,
    input  logic        reset_n,
    input  logic        enable,
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
    input  logic        testpat,
`endif
    output logic [16:0] ram_addr,
    output logic        ram_ce,
    input  logic [7:0]  ram_data,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o,
    output logic [7:0]  rgb_o,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_irq
);

    localparam int unsigned CW     = 11;
    localparam int unsigned DLY    = RD_LAT;
    localparam int unsigned H_SYNC_END = H_SYNC_START + H_SYNC_LEN;
    localparam int unsigned V_SYNC_END = V_SYNC_START + V_SYNC_LEN;

    if (H_ACTIVE > H_SYNC_START || H_SYNC_END > H_TOTAL ||
        V_ACTIVE > V_SYNC_START || V_SYNC_END > V_TOTAL ||
        H_ACTIVE > 512 || V_ACTIVE > 256 || RD_LAT < 1 || RD_LAT > 3) begin : g_param_check
        $error("video_sync_gen: illegal timing parameters");
    end

    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs;
    logic          vs;
    logic [7:0]    pix;

    logic [DLY-1:0] act_q;
    logic [DLY-1:0] hs_q;
    logic [DLY-1:0] vs_q;
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
    logic [DLY-1:0][7:0] hp_q;
    logic [DLY-1:0][3:0] vp_q;
`endif

    assign h_last = (hcount == CW'(H_TOTAL - 1));
    assign v_last = (vcount == CW'(V_TOTAL - 1));

    // Free-running raster counters
    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (enable) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + CW'(1);
            end else begin
                hcount <= hcount + CW'(1);
            end
        end
    end

    // Vertical sync window opens and closes at the hsync start point, so the
    // vsync edges line up with hsync falling edges.
    always_comb begin
        active = (hcount < CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE));
        hs     = (hcount >= CW'(H_SYNC_START)) && (hcount < CW'(H_SYNC_END));
        vs     = ((vcount > CW'(V_SYNC_START)) ||
                  ((vcount == CW'(V_SYNC_START)) && (hcount >= CW'(H_SYNC_START)))) &&
                 ((vcount < CW'(V_SYNC_END)) ||
                  ((vcount == CW'(V_SYNC_END)) && (hcount < CW'(H_SYNC_START))));
    end

    assign ram_addr = {vcount[7:0], hcount[8:0]};
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
    assign ram_ce   = reset_n & enable & active & ~testpat;
`else
    assign ram_ce   = reset_n & enable & active;
`endif

    // Delay line covering the RAM read latency; output registers form the last stage
    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
            hp_q  <= '0;
            vp_q  <= '0;
`endif
        end else if (enable) begin
            act_q[0] <= active;
            hs_q[0]  <= hs;
            vs_q[0]  <= vs;
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
            hp_q[0]  <= hcount[7:0];
            vp_q[0]  <= vcount[3:0];
`endif
            for (int i = 1; i < int'(DLY); i++) begin
                act_q[i] <= act_q[i-1];
                hs_q[i]  <= hs_q[i-1];
                vs_q[i]  <= vs_q[i-1];
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
                hp_q[i]  <= hp_q[i-1];
                vp_q[i]  <= vp_q[i-1];
`endif
            end
        end
    end

    always_comb begin
        pix = 8'h00;
        if (act_q[DLY-1]) begin
`ifdef VIDEO_SYNC_GEN_TESTPAT_EN
            if (!testpat) begin
                pix = ram_data;
            end else if (hp_q[DLY-1][3:0] == 4'h0 || vp_q[DLY-1] == 4'h0) begin
                pix = 8'hFF;
            end else begin
                pix = {hp_q[DLY-1][7:5], hp_q[DLY-1][7:5], hp_q[DLY-1][7:6]};
            end
`else
            pix = ram_data;
`endif
        end
    end

    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            blank_o <= 1'b1;
            rgb_o   <= 8'h00;
        end else if (enable) begin
            hsync_o <= ~hs_q[DLY-1];
            vsync_o <= ~vs_q[DLY-1];
            blank_o <= ~act_q[DLY-1];
            rgb_o   <= pix;
        end
    end

    // Strobes track the counters directly, without the pixel delay
    always_ff @(posedge clk6m or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank_irq  <= 1'b0;
        end else begin
            line_start  <= enable & h_last;
            frame_start <= enable & h_last & v_last;
            vblank_irq  <= enable & h_last & (vcount == CW'(V_ACTIVE - 1));
        end
    end

endmodule
